div_scheduler: RTL and testbench

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_pkg.sv | 19 +
 rtl/div_scheduler_if.sv | 45 ++++
 rtl/rr_arb2.sv | 19 +
 rtl/div_scheduler.sv | 125 ++++++++++++
 tb/tb_div_scheduler.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider scheduler: FSM states, operand width,
// default iteration count and the quotient reported on divide-by-zero.
package div_pkg;

   localparam int OP_W         = 4;
   localparam int ITER_DEFAULT = 4;

   typedef logic [OP_W-1:0] op_t;

   localparam op_t DZ_QUOT = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/div_scheduler_if.sv
// Request, result and divider-core signals of the scheduler. The scheduler
// attaches through the slave modport; requesters, consumer and core through master.
interface div_scheduler_if;
   import div_pkg::*;

   logic in0_valid;
   logic in0_ready;
   op_t  in0_dividend;
   op_t  in0_divisor;
   logic in1_valid;
   logic in1_ready;
   op_t  in1_dividend;
   op_t  in1_divisor;
   logic out_valid;
   logic out_ready;
   op_t  out_quotient;
   op_t  out_remainder;
   logic out_id;
   logic out_dz;
   logic div_load;
   op_t  div_dividend;
   op_t  div_divisor;
   op_t  div_quotient;
   op_t  div_remainder;
   logic busy;

   modport slave (
      input  in0_valid, in0_dividend, in0_divisor,
      input  in1_valid, in1_dividend, in1_divisor,
      input  out_ready, div_quotient, div_remainder,
      output in0_ready, in1_ready,
      output out_valid, out_quotient, out_remainder, out_id, out_dz,
      output div_load, div_dividend, div_divisor, busy
   );

   modport master (
      output in0_valid, in0_dividend, in0_divisor,
      output in1_valid, in1_dividend, in1_divisor,
      output out_ready, div_quotient, div_remainder,
      input  in0_ready, in1_ready,
      input  out_valid, out_quotient, out_remainder, out_id, out_dz,
      input  div_load, div_dividend, div_divisor, busy
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie is broken
// by ptr_i (the requester index currently favoured).
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_o,
   output logic       gnt_id_o
);

   logic any_req;

   assign any_req  = |req_i;
   assign gnt_id_o = (req_i[0] && req_i[1]) ? ptr_i : req_i[1];

   for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt_o[gi] = any_req && (gnt_id_o == 1'(gi));
   end

endmodule

// File: rtl/div_scheduler.sv
// Shares one external restoring divider between two requesters: arbitrates,
// loads the core, waits ITER+1 cycles and holds the result until consumed.
module div_scheduler
   import div_pkg::*;
#(
   parameter int ITER = ITER_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   div_scheduler_if.slave  bus
);

   localparam int CNT_W = (ITER > 0) ? $clog2(ITER + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER);

   state_e           state_q;
   logic             ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             id_q;
   logic             out_valid_q;
   op_t              out_quotient_q;
   op_t              out_remainder_q;
   logic             out_id_q;
   logic             out_dz_q;
   logic             div_load_q;
   op_t              div_dividend_q;
   op_t              div_divisor_q;

   logic [1:0] req;
   logic [1:0] gnt;
   logic       gnt_id;
   logic       accept;
   op_t        acc_dividend;
   op_t        acc_divisor;

   assign req = {bus.in1_valid, bus.in0_valid};

   rr_arb2 u_arb (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id)
   );

   // Readies exist only in IDLE, so nothing can be accepted while a result is held.
   assign bus.in0_ready = (state_q == IDLE) && gnt[0];
   assign bus.in1_ready = (state_q == IDLE) && gnt[1];
   assign accept        = (state_q == IDLE) && (|req);
   assign acc_dividend  = gnt_id ? bus.in1_dividend : bus.in0_dividend;
   assign acc_divisor   = gnt_id ? bus.in1_divisor  : bus.in0_divisor;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         ptr_q           <= 1'b0;
         cnt_q           <= '0;
         id_q            <= 1'b0;
         out_valid_q     <= 1'b0;
         out_quotient_q  <= '0;
         out_remainder_q <= '0;
         out_id_q        <= 1'b0;
         out_dz_q        <= 1'b0;
         div_load_q      <= 1'b0;
         div_dividend_q  <= '0;
         div_divisor_q   <= '0;
      end else begin
         div_load_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  ptr_q <= ~gnt_id;
                  id_q  <= gnt_id;
                  if (acc_divisor == '0) begin
                     out_valid_q     <= 1'b1;
                     out_dz_q        <= 1'b1;
                     out_quotient_q  <= DZ_QUOT;
                     out_remainder_q <= acc_dividend;
                     out_id_q        <= gnt_id;
                     state_q         <= DONE;
                  end else begin
                     div_dividend_q <= acc_dividend;
                     div_divisor_q  <= acc_divisor;
                     div_load_q     <= 1'b1;
                     state_q        <= LOAD;
                  end
               end
            end
            LOAD: begin
               cnt_q   <= '0;
               state_q <= RUN;
            end
            RUN: begin
               if (cnt_q == CNT_LAST) begin
                  out_valid_q     <= 1'b1;
                  out_dz_q        <= 1'b0;
                  out_quotient_q  <= bus.div_quotient;
                  out_remainder_q <= bus.div_remainder;
                  out_id_q        <= id_q;
                  state_q         <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.out_valid     = out_valid_q;
   assign bus.out_quotient  = out_quotient_q;
   assign bus.out_remainder = out_remainder_q;
   assign bus.out_id        = out_id_q;
   assign bus.out_dz        = out_dz_q;
   assign bus.div_load      = div_load_q;
   assign bus.div_dividend  = div_dividend_q;
   assign bus.div_divisor   = div_divisor_q;
   assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a behavioural divider core attached.
module tb_div_scheduler;
   import div_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic acc_ids[$];
   logic res_id[$];
   op_t  res_q[$];
   op_t  res_r[$];
   int   load_cnt;
   int   viol_cnt;

   div_scheduler_if bus ();

   div_scheduler #(.ITER(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural core: result is valid well before the scheduler captures it.
   assign bus.div_quotient  = (bus.div_divisor != 4'd0) ? bus.div_dividend / bus.div_divisor : 4'd0;
   assign bus.div_remainder = (bus.div_divisor != 4'd0) ? bus.div_dividend % bus.div_divisor : 4'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst) begin
         if (bus.in0_valid && bus.in0_ready) acc_ids.push_back(1'b0);
         if (bus.in1_valid && bus.in1_ready) acc_ids.push_back(1'b1);
         if (bus.div_load) load_cnt++;
         if (bus.out_valid && ((bus.in0_valid && bus.in0_ready) || (bus.in1_valid && bus.in1_ready)))
            viol_cnt++;
         if (bus.out_valid && bus.out_ready) begin
            res_id.push_back(bus.out_id);
            res_q.push_back(bus.out_quotient);
            res_r.push_back(bus.out_remainder);
            $display("result id=%0d quot=%0d rem=%0d dz=%0b t=%0t",
                     bus.out_id, bus.out_quotient, bus.out_remainder, bus.out_dz, $time);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
      checks++; if (bus.out_quotient !== 4'd0) begin failures++; $display("FAIL reset_quot got=%0h exp=0", bus.out_quotient); end
      checks++; if (bus.out_remainder !== 4'd0) begin failures++; $display("FAIL reset_rem got=%0h exp=0", bus.out_remainder); end
      checks++; if (bus.out_id !== 1'b0) begin failures++; $display("FAIL reset_id got=%0b exp=0", bus.out_id); end
      checks++; if (bus.out_dz !== 1'b0) begin failures++; $display("FAIL reset_dz got=%0b exp=0", bus.out_dz); end
      checks++; if (bus.div_load !== 1'b0) begin failures++; $display("FAIL reset_div_load got=%0b exp=0", bus.div_load); end
      checks++; if (bus.div_dividend !== 4'd0) begin failures++; $display("FAIL reset_div_dividend got=%0h exp=0", bus.div_dividend); end
      checks++; if (bus.div_divisor !== 4'd0) begin failures++; $display("FAIL reset_div_divisor got=%0h exp=0", bus.div_divisor); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
      rst = 1'b0;
      tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", bus.busy); end
      checks++; if ({bus.in1_ready, bus.in0_ready} !== 2'b00) begin failures++; $display("FAIL idle_ready got=%0b exp=00", {bus.in1_ready, bus.in0_ready}); end
   endtask

   task automatic test_basic();
      int lat;
      bus.in0_dividend = 4'd13;
      bus.in0_divisor  = 4'd3;
      bus.in0_valid    = 1'b1;
      #1;
      checks++; if ({bus.in1_ready, bus.in0_ready} !== 2'b01) begin failures++; $display("FAIL basic_ready got=%0b exp=01", {bus.in1_ready, bus.in0_ready}); end
      tick();
      bus.in0_valid = 1'b0;
      checks++; if (bus.div_load !== 1'b1) begin failures++; $display("FAIL basic_div_load got=%0b exp=1", bus.div_load); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", bus.busy); end
      checks++; if ({bus.div_dividend, bus.div_divisor} !== {4'd13, 4'd3}) begin failures++; $display("FAIL basic_operands got=%0d/%0d exp=13/3", bus.div_dividend, bus.div_divisor); end
      tick();
      checks++; if (bus.div_load !== 1'b0) begin failures++; $display("FAIL basic_load_pulse got=%0b exp=0", bus.div_load); end
      lat = 1;
      while (!bus.out_valid && lat < 20) begin tick(); lat++; end
      checks++; if (lat !== 6) begin failures++; $display("FAIL basic_latency got=%0d exp=6", lat); end
      checks++; if (bus.out_quotient !== 4'd4) begin failures++; $display("FAIL basic_quot got=%0d exp=4", bus.out_quotient); end
      checks++; if (bus.out_remainder !== 4'd1) begin failures++; $display("FAIL basic_rem got=%0d exp=1", bus.out_remainder); end
      checks++; if ({bus.out_id, bus.out_dz} !== 2'b00) begin failures++; $display("FAIL basic_id_dz got=%0b exp=00", {bus.out_id, bus.out_dz}); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++; if ({bus.out_valid, bus.busy} !== 2'b00) begin failures++; $display("FAIL basic_consume got=%0b exp=00", {bus.out_valid, bus.busy}); end
   endtask

   task automatic test_rr();
      int lat;
      do_reset();
      bus.in0_dividend = 4'd15; bus.in0_divisor = 4'd15; bus.in0_valid = 1'b1;
      bus.in1_dividend = 4'd7;  bus.in1_divisor = 4'd9;  bus.in1_valid = 1'b1;
      #1;
      checks++; if ({bus.in1_ready, bus.in0_ready} !== 2'b01) begin failures++; $display("FAIL rr_first_grant got=%0b exp=01", {bus.in1_ready, bus.in0_ready}); end
      tick();
      bus.in0_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin tick(); lat++; end
      checks++; if ({bus.out_quotient, bus.out_remainder, bus.out_id} !== {4'd1, 4'd0, 1'b0}) begin failures++; $display("FAIL rr_first_result got=%0d,%0d,id%0d exp=1,0,id0", bus.out_quotient, bus.out_remainder, bus.out_id); end
      checks++; if (bus.in1_ready !== 1'b0) begin failures++; $display("FAIL rr_ready_in_done got=%0b exp=0", bus.in1_ready); end
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.in1_ready !== 1'b0) begin failures++; $display("FAIL rr_ready_on_consume got=%0b exp=0", bus.in1_ready); end
      tick();
      bus.out_ready = 1'b0;
      checks++; if (bus.in1_ready !== 1'b1) begin failures++; $display("FAIL rr_second_grant got=%0b exp=1", bus.in1_ready); end
      tick();
      bus.in1_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin tick(); lat++; end
      checks++; if (lat !== 6) begin failures++; $display("FAIL rr_latency got=%0d exp=6", lat); end
      checks++; if ({bus.out_quotient, bus.out_remainder, bus.out_id} !== {4'd0, 4'd7, 1'b1}) begin failures++; $display("FAIL rr_second_result got=%0d,%0d,id%0d exp=0,7,id1", bus.out_quotient, bus.out_remainder, bus.out_id); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_dz();
      int base;
      base = load_cnt;
      bus.in1_dividend = 4'd9; bus.in1_divisor = 4'd0; bus.in1_valid = 1'b1;
      tick();
      bus.in1_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL dz_valid got=%0b exp=1", bus.out_valid); end
      checks++; if (bus.out_dz !== 1'b1) begin failures++; $display("FAIL dz_flag got=%0b exp=1", bus.out_dz); end
      checks++; if (bus.out_quotient !== 4'hF) begin failures++; $display("FAIL dz_quot got=%0h exp=f", bus.out_quotient); end
      checks++; if ({bus.out_remainder, bus.out_id} !== {4'd9, 1'b1}) begin failures++; $display("FAIL dz_rem_id got=%0d,id%0d exp=9,id1", bus.out_remainder, bus.out_id); end
      checks++; if ((load_cnt - base) !== 0 || bus.div_load !== 1'b0) begin failures++; $display("FAIL dz_no_load got=%0d exp=0", load_cnt - base); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int lat;
      bus.in0_dividend = 4'd6; bus.in0_divisor = 4'd4; bus.in0_valid = 1'b1;
      tick();
      bus.in0_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin tick(); lat++; end
      bus.in0_dividend = 4'd5; bus.in0_divisor = 4'd5; bus.in0_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({bus.out_valid, bus.out_quotient, bus.out_remainder} !== {1'b1, 4'd1, 4'd2}) begin failures++; $display("FAIL bp_hold%0d got=%0b,%0d,%0d exp=1,1,2", i, bus.out_valid, bus.out_quotient, bus.out_remainder); end
         checks++; if (bus.in0_ready !== 1'b0) begin failures++; $display("FAIL bp_ready%0d got=%0b exp=0", i, bus.in0_ready); end
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.in0_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_on_consume got=%0b exp=0", bus.in0_ready); end
      tick();
      bus.out_ready = 1'b0;
      checks++; if (bus.in0_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%0b exp=1", bus.in0_ready); end
      tick();
      bus.in0_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin tick(); lat++; end
      checks++; if ({bus.out_quotient, bus.out_remainder} !== {4'd1, 4'd0}) begin failures++; $display("FAIL bp_second got=%0d,%0d exp=1,0", bus.out_quotient, bus.out_remainder); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      bus.in0_dividend = 4'd12; bus.in0_divisor = 4'd5; bus.in0_valid = 1'b1;
      tick();
      bus.in0_valid = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      checks++; if ({bus.out_valid, bus.busy, bus.div_load} !== 3'b000) begin failures++; $display("FAIL rmid_ctrl got=%0b exp=000", {bus.out_valid, bus.busy, bus.div_load}); end
      checks++; if ({bus.div_dividend, bus.div_divisor, bus.out_quotient, bus.out_remainder} !== 16'h0) begin failures++; $display("FAIL rmid_data got=%0h exp=0", {bus.div_dividend, bus.div_divisor, bus.out_quotient, bus.out_remainder}); end
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (bus.out_valid) seen++; end
      checks++; if (seen !== 0) begin failures++; $display("FAIL rmid_no_result got=%0d exp=0", seen); end
      bus.in0_dividend = 4'd8; bus.in0_divisor = 4'd2; bus.in0_valid = 1'b1;
      tick();
      bus.in0_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin tick(); lat++; end
      checks++; if ({bus.out_quotient, bus.out_remainder, bus.out_dz} !== {4'd4, 4'd0, 1'b0}) begin failures++; $display("FAIL rmid_after got=%0d,%0d,dz%0b exp=4,0,dz0", bus.out_quotient, bus.out_remainder, bus.out_dz); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int abase;
      int rbase;
      int vbase;
      int n;
      int avail;
      op_t exp_q;
      op_t exp_r;
      do_reset();
      abase = acc_ids.size();
      rbase = res_id.size();
      vbase = viol_cnt;
      bus.in0_dividend = 4'd10; bus.in0_divisor = 4'd3; bus.in0_valid = 1'b1;
      bus.in1_dividend = 4'd14; bus.in1_divisor = 4'd4; bus.in1_valid = 1'b1;
      bus.out_ready = 1'b1;
      n = 0;
      while ((res_id.size() - rbase) < 4 && n < 80) begin tick(); n++; end
      bus.in0_valid = 1'b0; bus.in1_valid = 1'b0; bus.out_ready = 1'b0;
      avail = res_id.size() - rbase;
      checks++; if (avail < 4) begin failures++; $display("FAIL b2b_results got=%0d exp=4", avail); end
      for (int i = 0; i < 4 && i < avail; i++) begin
         exp_q = 4'd3;
         exp_r = (i % 2 == 0) ? 4'd1 : 4'd2;
         checks++; if (acc_ids[abase + i] !== 1'(i % 2)) begin failures++; $display("FAIL b2b_grant%0d got=%0d exp=%0d", i, acc_ids[abase + i], i % 2); end
         checks++; if ({res_id[rbase + i], res_q[rbase + i], res_r[rbase + i]} !== {1'(i % 2), exp_q, exp_r}) begin failures++; $display("FAIL b2b_result%0d got=id%0d,%0d,%0d exp=id%0d,%0d,%0d", i, res_id[rbase + i], res_q[rbase + i], res_r[rbase + i], i % 2, exp_q, exp_r); end
      end
      checks++; if (viol_cnt !== vbase) begin failures++; $display("FAIL b2b_accept_while_valid got=%0d exp=%0d", viol_cnt, vbase); end
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      load_cnt = 0;
      viol_cnt = 0;
      rst = 1'b1;
      bus.in0_valid = 1'b0; bus.in0_dividend = 4'd0; bus.in0_divisor = 4'd0;
      bus.in1_valid = 1'b0; bus.in1_dividend = 4'd0; bus.in1_divisor = 4'd0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_rr();
      test_dz();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
